// File: rtl/cpu_exec_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_exec_ctrl
//
// Execution controller for the board-level microprocessor. It produces a
// one-cycle clock enable (cpu_en) for the processor and supports three modes:
// - free-running execution at a divided rate;
// - debounced single-instruction stepping from a pushbutton;
// - a PC breakpoint that halts free-running execution.
//
// Optional feature macro: EXEC_CTRL_BREAKPOINT_EN
//   defined   : breakpoint compare present (BREAK state reachable)
//   undefined : bp_en / bp_addr / pc ignored, BREAK unreachable, bp_hit = 0
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous active-high reset
//   run_sw       in   1 = run mode, 0 = step mode (synchronous to clk)
//   key_n        in   raw active-low step pushbutton (asynchronous, bouncy)
//   bp_en        in   breakpoint enable
//   bp_addr[7:0] in   breakpoint PC value
//   pc[7:0]      in   processor program counter
//   cpu_state[1:0] in processor internal state
//   cpu_en       out  one-cycle processor advance enable (registered)
//   mode[1:0]    out  00 IDLE, 01 RUN, 10 STEP, 11 BREAK (registered)
//   bp_hit       out  high while in BREAK (registered)
//   instr_count[15:0] out completed-instruction counter
// -----------------------------------------------------------------------------
module cpu_exec_ctrl #(
    parameter int               DIV_W      = 15,
    parameter logic [DIV_W-1:0] DIV_MAX    = 15'd24999,
    parameter int               DB_W       = 16,
    parameter logic [DB_W-1:0]  DB_MAX     = 16'd49999,
    parameter logic [1:0]       LAST_STATE = 2'd3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run_sw,
    input  logic        key_n,
    input  logic        bp_en,
    input  logic [7:0]  bp_addr,
    input  logic [7:0]  pc,
    input  logic [1:0]  cpu_state,
    output logic        cpu_en,
    output logic [1:0]  mode,
    output logic        bp_hit,
    output logic [15:0] instr_count
);

    // The state encoding is the mode code presented to the display.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10,
        ST_BREAK = 2'b11
    } state_t;

    logic            r_key_sync1;
    logic            r_key_s;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_key_db;
    logic            r_press;
    logic [DIV_W-1:0] r_div;
    state_t          r_state;
    logic            r_cpu_en;
    logic [15:0]     r_instr_count;

    logic            w_key_diff;
    logic            w_tick;
    logic            w_bp_match;
    logic            w_last;
    state_t          w_state_nxt;
    logic            w_cpu_en_nxt;

    assign w_key_diff = (r_key_s != r_key_db);
    assign w_tick     = (r_div == DIV_MAX);
    assign w_last     = (cpu_state == LAST_STATE);

`ifdef EXEC_CTRL_BREAKPOINT_EN
    logic r_bp_hit;

    // Breakpoint fires only at an instruction boundary (cpu_state == 0).
    assign w_bp_match = bp_en && (pc == bp_addr) && (cpu_state == 2'd0);
    assign bp_hit     = r_bp_hit;

    // bp_hit tracks the registered BREAK state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bp_hit <= 1'b0;
        end else begin
            r_bp_hit <= (w_state_nxt == ST_BREAK);
        end
    end
`else
    logic w_unused_bp;

    assign w_unused_bp = ^{bp_en, bp_addr, pc};
    assign w_bp_match  = 1'b0;
    assign bp_hit      = 1'b0;
`endif

    // Two-flop synchronizer for the asynchronous pushbutton (idles high).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_key_sync1 <= 1'b1;
            r_key_s     <= 1'b1;
        end else begin
            r_key_sync1 <= key_n;
            r_key_s     <= r_key_sync1;
        end
    end

    // Debounce: key_db follows key_s only after DB_MAX+1 cycles of
    // disagreement; press pulses in the cycle key_db has just fallen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_db_cnt <= {DB_W{1'b0}};
            r_key_db <= 1'b1;
            r_press  <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (!w_key_diff) begin
                r_db_cnt <= {DB_W{1'b0}};
            end else if (r_db_cnt == DB_MAX) begin
                r_key_db <= r_key_s;
                r_db_cnt <= {DB_W{1'b0}};
                // A disagreement with key_s low means key_db is 1 -> 0.
                r_press  <= ~r_key_s;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end
    end

    // Free-running rate divider, independent of the FSM state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div <= {DIV_W{1'b0}};
        end else if (w_tick) begin
            r_div <= {DIV_W{1'b0}};
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Next-state and next-enable decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_cpu_en_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (run_sw) begin
                    w_state_nxt = ST_RUN;
                end else if (r_press) begin
                    w_state_nxt = ST_STEP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Leaving RUN suppresses the pulse even on a tick cycle.
                if (!run_sw) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_tick && w_bp_match) begin
                    w_state_nxt = ST_BREAK;
                end else if (w_tick) begin
                    w_cpu_en_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_STEP: begin
                w_cpu_en_nxt = w_tick;
                // Exit on the pulse that completes the instruction; a tick
                // cannot coincide with that pulse since ticks are >= 2 apart.
                if (r_cpu_en && w_last) begin
                    w_state_nxt = run_sw ? ST_RUN : ST_IDLE;
                end else begin
                    w_state_nxt = ST_STEP;
                end
            end
            ST_BREAK: begin
                if (!run_sw) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_press) begin
                    w_state_nxt = ST_STEP;
                end else begin
                    w_state_nxt = ST_BREAK;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and enable registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cpu_en <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cpu_en <= w_cpu_en_nxt;
        end
    end

    // Count instructions completed by an enable pulse in the last state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr_count <= 16'd0;
        end else if (r_cpu_en && w_last) begin
            r_instr_count <= r_instr_count + 16'd1;
        end else begin
            r_instr_count <= r_instr_count;
        end
    end

    assign cpu_en      = r_cpu_en;
    assign mode        = r_state;
    assign instr_count = r_instr_count;

endmodule

// File: tb/tb_cpu_exec_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for cpu_exec_ctrl (DIV_MAX=3, DB_MAX=3).
// A simple processor model advances cpu_state mod 4 on each cpu_en and bumps
// pc on wrap; a scoreboard counts pulses and completed instructions.
// -----------------------------------------------------------------------------
module tb_cpu_exec_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        run_sw;
    logic        key_n;
    logic        bp_en;
    logic [7:0]  bp_addr;
    logic [7:0]  pc;
    logic [1:0]  cpu_state;
    logic        cpu_en;
    logic [1:0]  mode;
    logic        bp_hit;
    logic [15:0] instr_count;

    cpu_exec_ctrl #(
        .DIV_W(15), .DIV_MAX(15'd3), .DB_W(16), .DB_MAX(16'd3), .LAST_STATE(2'd3)
    ) dut (
        .clk(clk), .reset(reset), .run_sw(run_sw), .key_n(key_n),
        .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .cpu_state(cpu_state),
        .cpu_en(cpu_en), .mode(mode), .bp_hit(bp_hit), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Processor model and scoreboard
    logic [1:0]  cs_m = 2'd0;
    logic [7:0]  pc_m = 8'd0;
    logic [15:0] exp_instr = 16'd0;
    logic        prev_en = 1'b0;
    int          cyc = 0;
    int          pulses = 0;
    int          consec_err = 0;
    int          nseq = 0;
    logic [1:0]  seq [0:1023];

    assign cpu_state = cs_m;
    assign pc        = pc_m;

    always @(posedge clk) begin
        prev_en <= cpu_en && !reset;
        if (reset) begin
            cyc       <= 0;
            cs_m      <= 2'd0;
            pc_m      <= 8'd0;
            exp_instr <= 16'd0;
        end else begin
            cyc <= cyc + 1;
            if (cpu_en) begin
                pulses <= pulses + 1;
                if (nseq < 1024) seq[nseq] <= cs_m;
                nseq <= nseq + 1;
                if (prev_en) consec_err <= consec_err + 1;
                cs_m <= cs_m + 2'd1;
                if (cs_m == 2'd3) begin
                    pc_m      <= pc_m + 8'd1;
                    exp_instr <= exp_instr + 16'd1;
                end
            end
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold the key low for low_len cycles; return once STEP has been seen
    // and then left (bounded).
    task automatic press_and_step(input int low_len, output bit saw, output bit done);
        saw  = 1'b0;
        done = 1'b0;
        key_n = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (i == low_len) key_n = 1'b1;
            step(1);
            if (mode == 2'b10) saw = 1'b1;
            if (saw && mode != 2'b10) begin
                done = 1'b1;
                break;
            end
        end
        key_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] i0;
        logic [15:0] d16;
        logic [7:0]  pc0;
        logic [7:0]  pat;
        logic [1:0]  s;
        int p0, n0, np, bad, last, exp_p, cnt;
        bit found, saw, done;

        reset = 1'b1; run_sw = 1'b0; key_n = 1'b1; bp_en = 1'b0; bp_addr = 8'h00;
        step(2);
        check("rst_cpu_en", 32'(cpu_en), 32'd0);
        check("rst_mode", 32'(mode), 32'd0);
        check("rst_bp_hit", 32'(bp_hit), 32'd0);
        check("rst_instr", 32'(instr_count), 32'd0);

        // Free-running: 64 cycles hold exactly 16 evenly spaced pulses
        reset = 1'b0; run_sw = 1'b1;
        step(6);
        i0 = instr_count; np = 0; bad = 0; last = -1;
        for (int i = 0; i < 64; i++) begin
            if (cpu_en === 1'b1) begin
                if (last >= 0 && (i - last) != 4) bad++;
                last = i;
                np++;
            end
            step(1);
        end
        d16 = instr_count - i0;
        check("run_pulses", 32'(np), 32'd16);
        check("run_gaps", 32'(bad), 32'd0);
        check("run_instr_delta", 32'(d16), 32'd4);
        check("run_mode", 32'(mode), 32'd1);
        check("run_instr_model", 32'(instr_count), 32'(exp_instr));

        // Reset mid-RUN
        reset = 1'b1;
        step(1);
        check("midrst_cpu_en", 32'(cpu_en), 32'd0);
        check("midrst_mode", 32'(mode), 32'd0);
        check("midrst_instr", 32'(instr_count), 32'd0);
        check("midrst_bp_hit", 32'(bp_hit), 32'd0);
        reset = 1'b0;
        step(8);

        // Drop run_sw on a tick cycle at an instruction boundary
        found = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if ((cyc % 4) == 3 && cs_m == 2'd0) begin
                found = 1'b1;
                break;
            end
            step(1);
        end
        check("tick_drop_found", 32'(found), 32'd1);
        run_sw = 1'b0;
        p0 = pulses;
        step(1);
        check("tick_drop_cpu_en", 32'(cpu_en), 32'd0);
        check("tick_drop_mode", 32'(mode), 32'd0);
        step(4);
        check("tick_drop_no_pulse", 32'(pulses - p0), 32'd0);

        // Single-instruction steps from IDLE
        for (int k = 0; k < 2; k++) begin
            p0 = pulses; n0 = nseq; i0 = instr_count; pc0 = pc_m;
            press_and_step(int'($urandom_range(7, 14)), saw, done);
            check("step_saw", 32'(saw), 32'd1);
            check("step_done", 32'(done), 32'd1);
            check("step_pulses", 32'(pulses - p0), 32'd4);
            pat = {seq[n0], seq[n0+1], seq[n0+2], seq[n0+3]};
            check("step_state_seq", 32'(pat), 32'h1b);
            d16 = instr_count - i0;
            check("step_instr_delta", 32'(d16), 32'd1);
            check("step_pc", 32'(pc_m), 32'(pc0 + 8'd1));
            check("step_mode_after", 32'(mode), 32'd0);
            step(10);
        end

        // Short glitches never produce a press
        p0 = pulses; bad = 0;
        for (int g = 0; g < 3; g++) begin
            key_n = 1'b0;
            np = int'($urandom_range(1, 3));
            for (int j = 0; j < np; j++) begin
                step(1);
                if (mode != 2'b00) bad++;
            end
            key_n = 1'b1;
            for (int j = 0; j < 8; j++) begin
                step(1);
                if (mode != 2'b00) bad++;
            end
        end
        check("glitch_mode", 32'(bad), 32'd0);
        check("glitch_pulses", 32'(pulses - p0), 32'd0);

        // Leave RUN mid-instruction; a press finishes only that instruction
        for (int k = 0; k < 3; k++) begin
            run_sw = 1'b1;
            step(int'($urandom_range(9, 40)));
            run_sw = 1'b0;
            step(4);
            check("mid_idle_mode", 32'(mode), 32'd0);
            s = cs_m; p0 = pulses;
            exp_p = (s == 2'd0) ? 4 : 4 - int'(s);
            press_and_step(int'($urandom_range(7, 14)), saw, done);
            check("mid_done", 32'(saw & done), 32'd1);
            check("mid_pulses", 32'(pulses - p0), 32'(exp_p));
            check("mid_cs_boundary", 32'(cs_m), 32'd0);
            check("mid_instr_model", 32'(instr_count), 32'(exp_instr));
            step(10);
        end

`ifdef EXEC_CTRL_BREAKPOINT_EN
        reset = 1'b1;
        step(2);
        reset = 1'b0; bp_en = 1'b1; bp_addr = 8'h05; run_sw = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step(1);
            if (mode == 2'b11) begin
                found = 1'b1;
                break;
            end
        end
        check("bp_found", 32'(found), 32'd1);
        check("bp_pc", 32'(pc_m), 32'h05);
        check("bp_cs", 32'(cs_m), 32'd0);
        check("bp_hit_high", 32'(bp_hit), 32'd1);
        p0 = pulses;
        step(20);
        check("bp_no_pulse", 32'(pulses - p0), 32'd0);
        check("bp_mode_hold", 32'(mode), 32'd3);
        p0 = pulses;
        press_and_step(int'($urandom_range(7, 14)), saw, done);
        check("bp_step_done", 32'(saw & done), 32'd1);
        check("bp_step_pulses", 32'(pulses - p0), 32'd4);
        check("bp_step_pc", 32'(pc_m), 32'h06);
        check("bp_resume_mode", 32'(mode), 32'd1);
        check("bp_hit_low", 32'(bp_hit), 32'd0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (mode == 2'b11 || bp_hit) cnt++;
        end
        check("bp_no_rehit", 32'(cnt), 32'd0);
`else
        reset = 1'b1;
        step(2);
        reset = 1'b0; bp_en = 1'b1; bp_addr = 8'h05; run_sw = 1'b1;
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            step(1);
            if (mode == 2'b11 || bp_hit) cnt++;
        end
        check("nobp_never_break", 32'(cnt), 32'd0);
        check("nobp_pc_passed", 32'(pc_m > 8'h05), 32'd1);
        check("nobp_mode_run", 32'(mode), 32'd1);
`endif

        check("no_consecutive_en", 32'(consec_err), 32'd0);
        check("final_instr_model", 32'(instr_count), 32'(exp_instr));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
